regfile_decoded: RTL and testbench

- Parameterised register file built around a generalised N-to-2^N one-hot write decoder.
- Synchronous decoded write port, two combinational read ports, optional hardwired-zero register and optional write-to-read bypass.
- Per-register "written since clear" flags drive read-valid outputs; a registered one-hot write trace is exported for debug.
- Sits in the datapath between instruction decode (register numbers) and the ALU operand muxes.

---
 rtl/regfile_decoded.sv | 113 +++++++++++
 tb/tb_regfile_decoded.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_decoded.sv
// Parameterised register file: one-hot decoded write port, two combinational
// read ports with optional bypass, per-register written flags and a write trace.
module regfile_decoded #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  rd_valid_a,
  output logic                  rd_valid_b,
  input  logic                  dirty_clr,
  output logic [NUM_REGS-1:0]   wr_onehot
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // wr_sel is the decoder output already qualified by acceptance, so it can
  // feed both the register enables and the debug trace directly.
  logic [NUM_REGS-1:0]   wr_sel;
  logic [DATA_WIDTH-1:0] reg_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [NUM_REGS-1:0]   wr_onehot_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (gi >= NUM_REGS) begin : g_unimpl
        assign reg_q[gi]   = '0;
        assign valid_q[gi] = 1'b0;
      end else if (ZERO_REG != 0 && gi == 0) begin : g_zero
        // Hardwired zero: never selected, always reads as a valid zero.
        assign wr_sel[gi]  = 1'b0;
        assign reg_q[gi]   = '0;
        assign valid_q[gi] = 1'b1;
      end else begin : g_impl
        logic [DATA_WIDTH-1:0] data_reg;
        logic                  dirty_reg;

        assign wr_sel[gi] = wr_en && rst_n && (wr_addr == ADDR_WIDTH'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            data_reg <= '0;
          end else if (wr_sel[gi]) begin
            data_reg <= wr_data;
          end
        end

        // A write on the same edge as a clear leaves the flag set.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            dirty_reg <= 1'b0;
          end else if (wr_sel[gi]) begin
            dirty_reg <= 1'b1;
          end else if (dirty_clr) begin
            dirty_reg <= 1'b0;
          end
        end

        assign reg_q[gi]   = data_reg;
        assign valid_q[gi] = dirty_reg;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_onehot_reg <= '0;
    end else begin
      wr_onehot_reg <= wr_sel;
    end
  end

  assign wr_onehot = wr_onehot_reg;

  logic [ADDR_WIDTH-1:0] rd_addr  [2];
  logic [DATA_WIDTH-1:0] rd_data  [2];
  logic                  rd_valid [2];

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic hit;

      if (BYPASS != 0) begin : g_byp
        assign hit = (|wr_sel) && (wr_addr == rd_addr[gi]);
      end else begin : g_nobyp
        assign hit = 1'b0;
      end

      assign rd_data[gi]  = hit ? wr_data : reg_q[rd_addr[gi]];
      assign rd_valid[gi] = hit | valid_q[rd_addr[gi]];
    end
  endgenerate

  assign rd_data_a  = rd_data[0];
  assign rd_data_b  = rd_data[1];
  assign rd_valid_a = rd_valid[0];
  assign rd_valid_b = rd_valid[1];

endmodule

// File: tb/tb_regfile_decoded.sv
// Bench for regfile_decoded: a default instance and a 24-register, no-bypass,
// no-zero-register instance, both checked against an array-based model.
module tb_regfile_decoded;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        dirty_clr;

  logic [31:0] d0a, d0b, d1a, d1b;
  logic        v0a, v0b, v1a, v1b;
  logic [31:0] oh0;
  logic [23:0] oh1;

  int tests  = 0;
  int failed = 0;

  logic [31:0] mem   [2][32];
  bit          dirty [2][32];

  always #5 clk = ~clk;

  regfile_decoded u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(d0a), .rd_data_b(d0b),
    .rd_valid_a(v0a), .rd_valid_b(v0b), .dirty_clr(dirty_clr), .wr_onehot(oh0)
  );

  regfile_decoded #(.NUM_REGS(24), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(d1a), .rd_data_b(d1b),
    .rd_valid_a(v1a), .rd_valid_b(v1b), .dirty_clr(dirty_clr), .wr_onehot(oh1)
  );

  function automatic int nregs(int k);
    return (k == 0) ? 32 : 24;
  endfunction

  function automatic bit has_zero(int k);
    return k == 0;
  endfunction

  function automatic bit has_bypass(int k);
    return k == 0;
  endfunction

  function automatic bit accepted(int k);
    return wr_en && (int'(wr_addr) < nregs(k)) && !(has_zero(k) && wr_addr == 5'd0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_read(input int k, input logic [4:0] a,
                          output logic [31:0] d, output logic v);
    if (int'(a) >= nregs(k)) begin
      d = 32'h0; v = 1'b0;
    end else if (has_zero(k) && a == 5'd0) begin
      d = 32'h0; v = 1'b1;
    end else if (has_bypass(k) && accepted(k) && wr_addr == a) begin
      d = wr_data; v = 1'b1;
    end else begin
      d = mem[k][a]; v = dirty[k][a];
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        mem[k][i] = 32'h0; dirty[k][i] = 1'b0;
      end
  endtask

  // One cycle: drive, check reads before the edge, update model, check trace.
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] ra, input logic [4:0] rb, input logic clr);
    logic [31:0] ed_a, ed_b, eoh [2];
    logic        ev_a, ev_b;
    bit          acc [2];
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb; dirty_clr = clr;
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_read(k, ra, ed_a, ev_a);
      exp_read(k, rb, ed_b, ev_b);
      check($sformatf("dut%0d rd_data_a@%0d", k, ra), (k == 0) ? d0a : d1a, ed_a);
      check($sformatf("dut%0d rd_valid_a@%0d", k, ra), {31'b0, (k == 0) ? v0a : v1a}, {31'b0, ev_a});
      check($sformatf("dut%0d rd_data_b@%0d", k, rb), (k == 0) ? d0b : d1b, ed_b);
      check($sformatf("dut%0d rd_valid_b@%0d", k, rb), {31'b0, (k == 0) ? v0b : v1b}, {31'b0, ev_b});
      acc[k] = accepted(k);
      eoh[k] = acc[k] ? (32'h1 << wa) : 32'h0;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (clr) for (int i = 0; i < 32; i++) dirty[k][i] = 1'b0;
      if (acc[k]) begin
        mem[k][wa] = wd; dirty[k][wa] = 1'b1;
      end
    end
    #1;
    check("dut0 wr_onehot", oh0, eoh[0]);
    check("dut1 wr_onehot", {8'h0, oh1}, eoh[1]);
  endtask

  initial begin
    clear_model();
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_0000;
    rd_addr_a = 5'd5; rd_addr_b = 5'd0; dirty_clr = 1'b0;
    #12;
    check("rst dut0 data_a", d0a, 32'h0);
    check("rst dut0 valid_a", {31'b0, v0a}, 32'h0);
    check("rst dut0 valid_b r0", {31'b0, v0b}, 32'h1);
    check("rst dut1 data_a", d1a, 32'h0);
    check("rst dut1 valid_b", {31'b0, v1b}, 32'h0);
    check("rst dut0 onehot", oh0, 32'h0);
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd31, 5'd5, 1'b0);
    step(1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0);
    step(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd7, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0);
    step(1'b1, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd3, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0);
    step(1'b1, 5'd4, 32'h1111_1111, 5'd4, 5'd9, 1'b0);
    step(1'b1, 5'd9, 32'h2222_2222, 5'd4, 5'd9, 1'b0);
    step(1'b1, 5'd9, 32'h0000_0055, 5'd4, 5'd9, 1'b1);
    step(1'b0, 5'd0, 32'h0, 5'd4, 5'd9, 1'b0);
    step(1'b1, 5'd28, 32'h7777_7777, 5'd28, 5'd28, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd28, 5'd23, 1'b0);
    step(1'b1, 5'd23, 32'h0BAD_F00D, 5'd23, 5'd24, 1'b0);
    step(1'b1, 5'd23, 32'h0000_0001, 5'd23, 5'd23, 1'b0);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, ra, rb;
      wa = 5'($urandom);
      ra = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      step($urandom_range(0, 3) != 0, wa, $urandom, ra, rb, $urandom_range(0, 7) == 0);
    end

    // Reset dropped in the middle of a cycle with a write pending.
    step(1'b1, 5'd12, 32'hCAFE_0001, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h1357_9BDF;
    rd_addr_a = 5'd12; rd_addr_b = 5'd7; dirty_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst dut0 data_a", d0a, 32'h0);
    check("midrst dut0 valid_a", {31'b0, v0a}, 32'h0);
    check("midrst dut0 data_b", d0b, 32'h0);
    check("midrst dut0 valid_b", {31'b0, v0b}, 32'h0);
    check("midrst dut1 data_a", d1a, 32'h0);
    check("midrst dut1 valid_b", {31'b0, v1b}, 32'h0);
    check("midrst dut0 onehot", oh0, 32'h0);
    clear_model();
    @(posedge clk);
    #1;
    check("midrst edge dut0 data_a", d0a, 32'h0);
    check("midrst edge dut1 onehot", {8'h0, oh1}, 32'h0);
    @(negedge clk);
    wr_en = 1'b0; rst_n = 1'b1;
    step(1'b0, 5'd0, 32'h0, 5'd12, 5'd0, 1'b0);
    step(1'b1, 5'd12, 32'h0000_ABCD, 5'd12, 5'd7, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd12, 5'd7, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
